otp_sram_key_rsp: RTL

OTP-side responder for the SRAM scrambling-key request interface: it answers an SRAM controller's key request with a fresh key, nonce and seed-valid flag. It sits in the OTP controller's fixed-clock domain, directly at the far end of the SRAM controller's key request/acknowledge pair. Entropy is collected word by word from EDN, mixed with the OTP root seed over a fixed number of rounds, and returned on a single-cycle acknowledge. Life-cycle escalation forces a terminal error state that serves only netlist constants.

---
 rtl/otp_sram_key_rsp_pkg.sv | 34 +++
 rtl/otp_sram_key_rsp_lfsr.sv | 25 ++
 rtl/otp_sram_key_rsp.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/otp_sram_key_rsp_pkg.sv
// Shared state encoding and netlist constants for otp_sram_key_rsp.
package otp_sram_key_rsp_pkg;

  // Sparse encoding so single-bit upsets land in the illegal space.
  typedef enum logic [4:0] {
    StIdle    = 5'b10110,
    StEntropy = 5'b01101,
    StDerive  = 5'b11000,
    StAck     = 5'b00011,
    StError   = 5'b10001
  } state_e;

  localparam int unsigned RotAmt = 13;

  localparam logic [31:0] LfsrPoly = 32'h8020_0003;

  localparam logic [3:0] LcTxOff = 4'b1010;

  localparam logic [127:0] RndCnstKeyDefault =
    128'h3ba7_1f5c_9e04_d2a8_6b13_c7f0_45e9_8d21;

  localparam logic [63:0] RndCnstNonceDefault =
    64'h5d2c_e81f_a7b3_0946;

  localparam logic [31:0] RndCnstLfsrSeedDefault =
    32'h1d3a_9c47;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    return {1'b0, s[31:1]} ^ (s[0] ? LfsrPoly : 32'h0);
  endfunction

endpackage

// File: rtl/otp_sram_key_rsp_lfsr.sv
// Free-running 32-bit Galois LFSR; stands in for EDN
// when OTP_SRAM_KEY_RSP_EDN_EN is not defined.
module otp_sram_key_rsp_lfsr
  import otp_sram_key_rsp_pkg::*;
#(
  parameter logic [31:0] Seed = RndCnstLfsrSeedDefault
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] word_o
);

  logic [31:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  assign word_o = lfsr_q;

endmodule

// File: rtl/otp_sram_key_rsp.sv
// OTP-side SRAM key responder. Define OTP_SRAM_KEY_RSP_EDN_EN
// to draw entropy from EDN instead of the internal LFSR.
module otp_sram_key_rsp
  import otp_sram_key_rsp_pkg::*;
#(
  parameter int unsigned KeyWidth   = 128,
  parameter int unsigned NonceWidth = 64,
  parameter int unsigned NumRounds  = 4,
  parameter logic [KeyWidth-1:0] RndCnstKey =
    RndCnstKeyDefault,
  parameter logic [NonceWidth-1:0] RndCnstNonce =
    RndCnstNonceDefault,
  parameter logic [31:0] RndCnstLfsrSeed =
    RndCnstLfsrSeedDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  key_req_i,
  output logic                  key_ack_o,
  output logic [KeyWidth-1:0]   key_o,
  output logic [NonceWidth-1:0] nonce_o,
  output logic                  seed_valid_o,
  input  logic [KeyWidth-1:0]   otp_seed_i,
  input  logic                  otp_seed_valid_i,
  output logic                  edn_req_o,
  input  logic                  edn_ack_i,
  input  logic [31:0]           edn_bits_i,
  input  logic [3:0]            lc_escalate_en_i
);

  localparam int unsigned EntW = KeyWidth + NonceWidth;
  localparam int unsigned NumWords = EntW / 32;
  localparam int unsigned WcntW =
    (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned RcntW = $clog2(NumRounds + 1);
  localparam logic [WcntW-1:0] LastWord =
    WcntW'(NumWords - 1);
  localparam logic [RcntW-1:0] LastRound =
    RcntW'(NumRounds);

  function automatic logic [KeyWidth-1:0] rotl(
    input logic [KeyWidth-1:0] v
  );
    return {v[KeyWidth-RotAmt-1:0],
            v[KeyWidth-1 -: RotAmt]};
  endfunction

  logic [31:0] word;
  logic        word_vld;

`ifdef OTP_SRAM_KEY_RSP_EDN_EN
  localparam logic EdnEn = 1'b1;
  assign word     = edn_bits_i;
  assign word_vld = edn_ack_i;
`else
  localparam logic EdnEn = 1'b0;
  logic [31:0] lfsr_word;
  logic        unused_edn;

  otp_sram_key_rsp_lfsr #(
    .Seed (RndCnstLfsrSeed)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .word_o (lfsr_word)
  );

  assign word       = lfsr_word;
  assign word_vld   = 1'b1;
  assign unused_edn = ^{edn_ack_i, edn_bits_i};
`endif

  state_e                state_q;
  logic                  armed_q;
  logic [EntW-1:0]       ent_q;
  logic [KeyWidth-1:0]   s_q;
  logic [WcntW-1:0]      wcnt_q;
  logic [RcntW-1:0]      rcnt_q;
  logic                  sv_q;
  logic                  ack_q;
  logic [KeyWidth-1:0]   key_q;
  logic [NonceWidth-1:0] nonce_q;
  logic                  sv_out_q;
  logic                  edn_req_q;

  logic                escalate;
  logic                accept;
  logic [KeyWidth-1:0] s_load;
  logic [KeyWidth-1:0] s_round;

  assign escalate = lc_escalate_en_i != LcTxOff;
  assign accept   = key_req_i && armed_q;
  assign s_load   =
    (otp_seed_valid_i ? otp_seed_i : RndCnstKey)
    ^ ent_q[KeyWidth-1:0];
  assign s_round  = rotl(s_q) ^ RndCnstKey;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      armed_q   <= 1'b1;
      ent_q     <= '0;
      s_q       <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      sv_q      <= 1'b0;
      ack_q     <= 1'b0;
      key_q     <= '0;
      nonce_q   <= '0;
      sv_out_q  <= 1'b0;
      edn_req_q <= 1'b0;
    end else begin
      // Data is only driven during the ack cycle.
      ack_q    <= 1'b0;
      key_q    <= '0;
      nonce_q  <= '0;
      sv_out_q <= 1'b0;
      armed_q  <= armed_q | ~key_req_i;
      if (escalate && state_q != StError) begin
        state_q   <= StError;
        edn_req_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (accept) begin
              state_q   <= StEntropy;
              armed_q   <= 1'b0;
              wcnt_q    <= '0;
              edn_req_q <= EdnEn;
            end
          end
          StEntropy: begin
            if (word_vld) begin
              ent_q[{wcnt_q, 5'b0} +: 32] <= word;
              wcnt_q <= wcnt_q + 1'b1;
              if (wcnt_q == LastWord) begin
                state_q   <= StDerive;
                rcnt_q    <= '0;
                edn_req_q <= 1'b0;
              end
            end
          end
          StDerive: begin
            if (rcnt_q == '0) begin
              s_q    <= s_load;
              sv_q   <= otp_seed_valid_i;
              rcnt_q <= rcnt_q + 1'b1;
            end else begin
              s_q    <= s_round;
              rcnt_q <= rcnt_q + 1'b1;
              if (rcnt_q == LastRound) begin
                state_q  <= StAck;
                ack_q    <= 1'b1;
                key_q    <= s_round;
                nonce_q  <=
                  ent_q[KeyWidth +: NonceWidth];
                sv_out_q <= sv_q;
              end
            end
          end
          StAck: begin
            state_q <= StIdle;
          end
          StError: begin
            if (accept) begin
              armed_q <= 1'b0;
              ack_q   <= 1'b1;
              key_q   <= RndCnstKey;
              nonce_q <= RndCnstNonce;
            end
          end
          default: begin
            state_q   <= StError;
            edn_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_ack_o    = ack_q;
  assign key_o        = key_q;
  assign nonce_o      = nonce_q;
  assign seed_valid_o = sv_out_q;
  assign edn_req_o    = edn_req_q;

endmodule
